move_keypad: RTL

Per-player move-entry front end for the Dooz (tic-tac-toe) board. It debounces two banks of nine raw cell push-buttons and encodes each accepted press as a cell code 1..9. It presents the code on `p1`/`p2` for a fixed number of cycles, then waits for release before accepting another press. It sits directly upstream of the game controller `mainPage` and drives that block's `p1`/`p2` inputs; it takes `mainPage`'s `turnA`/`turnB` outputs back as gating inputs.

---
 rtl/move_keypad.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/move_keypad.sv
// Two-player debounced cell-button encoder feeding the Dooz game controller.
// Optional MOVE_TURN_GATE_EN: presses are only accepted while the player's turn input is high.

// state    | meaning
// IDLE     | waiting for an exactly one-hot sample
// DEBOUNCE | counting identical samples of the captured button
// EMIT     | presenting the captured cell code
// RELEASE  | waiting for enough consecutive all-released samples
module move_keypad_fsm #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] smp,
  input  logic       turn,
  output logic [3:0] code,
  output logic       press
);
  localparam logic [7:0] DB_CNT   = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] HOLD_CNT = 8'(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, EMIT, RELEASE} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cap_q, cap_d;
  logic [3:0] code_q, code_d;
  logic       press_q, press_d;
  logic       turn_ok;
  logic       smp_onehot;
  logic [3:0] smp_cell;
  logic [8:0] cap_vec;

`ifdef MOVE_TURN_GATE_EN
  assign turn_ok = turn;
`else
  logic unused_turn;
  assign unused_turn = turn;
  assign turn_ok     = 1'b1;
`endif

  always_comb begin
    smp_onehot = ($countones(smp) == 1);
    smp_cell   = 4'd0;
    for (int k = 0; k < 9; k++) begin
      if (smp[k]) smp_cell = 4'(k + 1);
    end
    cap_vec = 9'd1 << (cap_q - 4'd1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    code_d  = 4'd0;
    press_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (smp_onehot && turn_ok) begin
          cap_d   = smp_cell;
          cnt_d   = 8'd1;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (smp != cap_vec || !turn_ok) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (cnt_q == DB_CNT) begin
          cnt_d   = 8'd1;
          code_d  = cap_q;
          press_d = 1'b1;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      EMIT: begin
        if (cnt_q == HOLD_CNT) begin
          cnt_d   = 8'd0;
          state_d = RELEASE;
        end else begin
          cnt_d  = cnt_q + 8'd1;
          code_d = cap_q;
        end
      end
      RELEASE: begin
        // any bounce back to pressed restarts the release window
        if (smp != 9'd0) begin
          cnt_d = 8'd0;
        end else if (cnt_q + 8'd1 == DB_CNT) begin
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      cap_q   <= 4'd0;
      code_q  <= 4'd0;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      code_q  <= code_d;
      press_q <= press_d;
    end
  end

  assign code  = code_q;
  assign press = press_q;
endmodule

module move_keypad #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned HOLD_CYCLES     = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [8:0] btnA,
  input  logic [8:0] btnB,
  input  logic       turnA,
  input  logic       turnB,
  output logic [3:0] p1,
  output logic [3:0] p2,
  output logic       pressA,
  output logic       pressB
);
  logic [8:0] sa_q, sa_d;
  logic [8:0] sb_q, sb_d;

  always_comb begin
    sa_d = btnA;
    sb_d = btnB;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa_q <= 9'd0;
      sb_q <= 9'd0;
    end else begin
      sa_q <= sa_d;
      sb_q <= sb_d;
    end
  end

  move_keypad_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_fsm_a (
    .clk  (clk),
    .reset(reset),
    .smp  (sa_q),
    .turn (turnA),
    .code (p1),
    .press(pressA)
  );

  move_keypad_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .HOLD_CYCLES    (HOLD_CYCLES)
  ) u_fsm_b (
    .clk  (clk),
    .reset(reset),
    .smp  (sb_q),
    .turn (turnB),
    .code (p2),
    .press(pressB)
  );
endmodule
